// File: rtl/ctu_sync_pulse_gen_if.sv
// ---------------------------------------------------------------------------
// ctu_sync_pulse_gen_if
//
// Purpose:
//   Groups the control inputs and the strobe outputs of ctu_sync_pulse_gen.
//   The clock and reset stay plain ports on the generator.
//
// Signals:
//   sync_en              run enable (master -> slave)
//   jbus_ratio           CMP cycles per JBUS cycle (master -> slave)
//   dram_ratio           CMP cycles per DRAM cycle (master -> slave)
//   jbus_rx_sync_global  JBUS capture strobe (slave -> master)
//   jbus_tx_sync_global  JBUS launch strobe (slave -> master)
//   dram_rx_sync_global  DRAM capture strobe (slave -> master)
//   dram_tx_sync_global  DRAM launch strobe (slave -> master)
//   ratio_err            sticky illegal-ratio flag (slave -> master)
//
// Modports:
//   master  clock-control side that programs ratios and consumes strobes
//   slave   the pulse generator itself
// ---------------------------------------------------------------------------
interface ctu_sync_pulse_gen_if #(
  parameter int RATIO_W = 5
) ();

  logic               sync_en;
  logic [RATIO_W-1:0] jbus_ratio;
  logic [RATIO_W-1:0] dram_ratio;
  logic               jbus_rx_sync_global;
  logic               jbus_tx_sync_global;
  logic               dram_rx_sync_global;
  logic               dram_tx_sync_global;
  logic               ratio_err;

  modport master (
    output sync_en,
    output jbus_ratio,
    output dram_ratio,
    input  jbus_rx_sync_global,
    input  jbus_tx_sync_global,
    input  dram_rx_sync_global,
    input  dram_tx_sync_global,
    input  ratio_err
  );

  modport slave (
    input  sync_en,
    input  jbus_ratio,
    input  dram_ratio,
    output jbus_rx_sync_global,
    output jbus_tx_sync_global,
    output dram_rx_sync_global,
    output dram_tx_sync_global,
    output ratio_err
  );

endinterface

// File: rtl/ctu_sync_pulse_gen.sv
// ---------------------------------------------------------------------------
// ctu_sync_pulse_gen
//
// Purpose:
//   Produces the four global sync strobes in the CMP clock domain. Two
//   identical, independent phase counters (JBUS, DRAM) each run over a
//   programmable number of CMP cycles per slow-clock period and fire a
//   one-cycle rx strobe at phase RX_OFFSET and a one-cycle tx strobe at the
//   last phase of the period.
//
// Parameters:
//   RATIO_W    width of ratio inputs and phase counters (legal ratio 2..2^W-1)
//   RX_OFFSET  phase of the rx strobe, 0 or 1
//
// Ports:
//   cmp_gclk    CMP clock, the only clock
//   cmp_grst_l  asynchronous active-low reset
//   bus         ctu_sync_pulse_gen_if.slave: sync_en, jbus_ratio, dram_ratio
//               in; four sync strobes and ratio_err out
//
// Build option:
//   CTU_SYNC_RATIO_CHECK_EN  when defined, ratio_err becomes a sticky flag
//               that sets whenever a ratio register loads from an input of
//               0 or 1. When undefined, ratio_err is tied low and no check
//               logic exists. Clamping of 0/1 to 2 happens in both builds.
// ---------------------------------------------------------------------------
module ctu_sync_pulse_gen #(
  parameter int RATIO_W   = 5,
  parameter int RX_OFFSET = 1
) (
  input  logic                 cmp_gclk,
  input  logic                 cmp_grst_l,
  ctu_sync_pulse_gen_if.slave  bus
);

  localparam int NUM_DOM = 2;  // 0 = JBUS, 1 = DRAM

  localparam logic [RATIO_W-1:0] RATIO_MIN = RATIO_W'(2);
  localparam logic [RATIO_W-1:0] RATIO_ONE = RATIO_W'(1);
  localparam logic [RATIO_W-1:0] RX_PHASE  = RATIO_W'(RX_OFFSET);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // -------------------------------------------------------------------------
  // Per-domain phase counter and strobe generation
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_DOM; gi++) begin : g_dom

    logic [RATIO_W-1:0] ratio_in;
    logic [RATIO_W-1:0] ratio_clamped;
    logic               ratio_illegal;

    state_e             state_q, state_d;
    logic [RATIO_W-1:0] phase_q, phase_d;
    logic [RATIO_W-1:0] ratio_q, ratio_d;
    logic               rx_q, rx_d;
    logic               tx_q, tx_d;
    logic               load_ratio;   // active-ratio register reloads at this edge
    logic               bad_load;     // ...and the value being loaded was 0 or 1

    assign ratio_in      = (gi == 0) ? bus.jbus_ratio : bus.dram_ratio;
    assign ratio_illegal = (ratio_in < RATIO_MIN);
    assign ratio_clamped = ratio_illegal ? RATIO_MIN : ratio_in;
    assign bad_load      = load_ratio & ratio_illegal;

    always_ff @(posedge cmp_gclk or negedge cmp_grst_l) begin
      if (!cmp_grst_l) begin
        state_q <= ST_IDLE;
        phase_q <= '0;
        ratio_q <= RATIO_MIN;
        rx_q    <= 1'b0;
        tx_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        phase_q <= phase_d;
        ratio_q <= ratio_d;
        rx_q    <= rx_d;
        tx_q    <= tx_d;
      end
    end

    // The strobes are registered versions of a decode of the *next* phase
    // and ratio, so they are high exactly during the cycle in which the
    // counter holds the matching phase while still coming straight from
    // flops.
    always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      ratio_d    = ratio_q;
      load_ratio = 1'b0;
      rx_d       = 1'b0;
      tx_d       = 1'b0;

      if (!bus.sync_en) begin
        // Idle: hold phase 0 and keep tracking the ratio input so the first
        // period after enable already uses the programmed value.
        state_d    = ST_IDLE;
        phase_d    = '0;
        load_ratio = 1'b1;
      end else if (state_q == ST_IDLE) begin
        // Enable edge (E0): cycle 0 of the first period.
        state_d    = ST_RUN;
        phase_d    = '0;
        load_ratio = 1'b1;
      end else if (phase_q == ratio_q - RATIO_ONE) begin
        // Wrap edge: the only place a running domain picks up a new ratio,
        // so a period is never shortened or stretched by a mid-period write.
        phase_d    = '0;
        load_ratio = 1'b1;
      end else begin
        phase_d    = phase_q + RATIO_ONE;
      end

      if (load_ratio) begin
        ratio_d = ratio_clamped;
      end

      if (state_d == ST_RUN) begin
        rx_d = (phase_d == RX_PHASE);
        tx_d = (phase_d == ratio_d - RATIO_ONE);
      end
    end

  end : g_dom

  assign bus.jbus_rx_sync_global = g_dom[0].rx_q;
  assign bus.jbus_tx_sync_global = g_dom[0].tx_q;
  assign bus.dram_rx_sync_global = g_dom[1].rx_q;
  assign bus.dram_tx_sync_global = g_dom[1].tx_q;

  // -------------------------------------------------------------------------
  // Illegal-ratio flag
  // -------------------------------------------------------------------------
`ifdef CTU_SYNC_RATIO_CHECK_EN
  logic ratio_err_q, ratio_err_d;

  // Sticky until reset; sync_en has no influence on it.
  assign ratio_err_d = ratio_err_q | g_dom[0].bad_load | g_dom[1].bad_load;

  always_ff @(posedge cmp_gclk or negedge cmp_grst_l) begin
    if (!cmp_grst_l) begin
      ratio_err_q <= 1'b0;
    end else begin
      ratio_err_q <= ratio_err_d;
    end
  end

  assign bus.ratio_err = ratio_err_q;
`else
  assign bus.ratio_err = 1'b0;
`endif

endmodule

// File: tb/tb_ctu_sync_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_ctu_sync_pulse_gen
//
// Directed sequence followed by a randomized run. Expected strobes come from
// a period-level reference model: each domain remembers the absolute cycle
// at which its current period started and that period's length; rx is due at
// start+RX_OFFSET and tx at start+len-1. Outputs are checked at the falling
// edge, inputs change right after the check.
// ---------------------------------------------------------------------------
module tb_ctu_sync_pulse_gen;

  localparam int RATIO_W   = 5;
  localparam int RX_OFFSET = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ctu_sync_pulse_gen_if #(.RATIO_W(RATIO_W)) bus ();

  ctu_sync_pulse_gen #(
    .RATIO_W   (RATIO_W),
    .RX_OFFSET (RX_OFFSET)
  ) dut (
    .cmp_gclk   (clk),
    .cmp_grst_l (rst_n),
    .bus        (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state (index 0 = JBUS, 1 = DRAM)
  bit m_en    [2];
  int m_k     [2];   // cycles since enable edge
  int m_start [2];   // cycle at which the current period began
  int m_len   [2];   // length of the current period
  bit m_err;

  function automatic int clamp_ratio(int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic int ratio_of(int d);
    return (d == 0) ? int'(bus.jbus_ratio) : int'(bus.dram_ratio);
  endfunction

  function automatic bit exp_rx(int d);
    return m_en[d] && ((m_k[d] - m_start[d]) == RX_OFFSET);
  endfunction

  function automatic bit exp_tx(int d);
    return m_en[d] && (m_k[d] == m_start[d] + m_len[d] - 1);
  endfunction

  function automatic bit exp_err();
`ifdef CTU_SYNC_RATIO_CHECK_EN
    return m_err;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_en[d]    = 1'b0;
      m_k[d]     = 0;
      m_start[d] = 0;
      m_len[d]   = 2;
    end
    m_err = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs it samples.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int r    = ratio_of(d);
      bit load = 1'b0;
      if (!bus.sync_en) begin
        m_en[d] = 1'b0;
        load    = 1'b1;
      end else if (!m_en[d]) begin
        m_en[d]    = 1'b1;
        m_k[d]     = 0;
        m_start[d] = 0;
        load       = 1'b1;
      end else begin
        m_k[d]++;
        if (m_k[d] == m_start[d] + m_len[d]) begin
          m_start[d] = m_k[d];
          load       = 1'b1;
        end
      end
      if (load) begin
        m_len[d] = clamp_ratio(r);
        if (r < 2) m_err = 1'b1;
      end
    end
  endtask

  task automatic chk(string tag, logic obs, logic expv);
    checks++;
    assert (obs === expv)
      else begin
        failures++;
        $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
      end
  endtask

  task automatic check_all(string phase);
    chk({phase, ":jbus_rx"}, bus.jbus_rx_sync_global, exp_rx(0));
    chk({phase, ":jbus_tx"}, bus.jbus_tx_sync_global, exp_tx(0));
    chk({phase, ":dram_rx"}, bus.dram_rx_sync_global, exp_rx(1));
    chk({phase, ":dram_tx"}, bus.dram_tx_sync_global, exp_tx(1));
    chk({phase, ":ratio_err"}, bus.ratio_err, exp_err());
    $display("%-6s cyc=%0d rst_n=%b en=%b jr=%0d dr=%0d | jrx=%b jtx=%b drx=%b dtx=%b err=%b",
             phase, cyc, rst_n, bus.sync_en, bus.jbus_ratio, bus.dram_ratio,
             bus.jbus_rx_sync_global, bus.jbus_tx_sync_global,
             bus.dram_rx_sync_global, bus.dram_tx_sync_global, bus.ratio_err);
  endtask

  task automatic step(string phase);
    @(posedge clk);
    if (rst_n) model_edge();
    cyc++;
    @(negedge clk);
    check_all(phase);
  endtask

  initial begin
    model_reset();
    bus.sync_en    = 1'b0;
    bus.jbus_ratio = RATIO_W'(2);
    bus.dram_ratio = RATIO_W'(2);
    rst_n          = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    step("idle");

    // Basic periods: JBUS 4, DRAM 6
    bus.jbus_ratio = RATIO_W'(4);
    bus.dram_ratio = RATIO_W'(6);
    bus.sync_en    = 1'b1;
    repeat (20) step("basic");

    // Ratio change mid-period: JBUS 4 -> 3 during cycle 5
    bus.sync_en = 1'b0;
    repeat (2) step("idle");
    bus.sync_en = 1'b1;
    repeat (6) step("rchg");
    bus.jbus_ratio = RATIO_W'(3);
    repeat (10) step("rchg");

    // Disable at the edge ending cycle 6, then re-enable
    bus.sync_en    = 1'b0;
    bus.jbus_ratio = RATIO_W'(4);
    step("idle");
    bus.sync_en = 1'b1;
    repeat (7) step("dis");
    bus.sync_en = 1'b0;
    repeat (2) step("dis");
    bus.sync_en = 1'b1;
    repeat (8) step("reen");

    // Reset asserted asynchronously during a JBUS tx cycle
    for (int i = 0; i < 20 && !exp_tx(0); i++) step("pre_rst");
    chk("pre_rst:tx_reached", bus.jbus_tx_sync_global, 1'b1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("rst");
    repeat (2) step("rst");
    rst_n          = 1'b1;
    bus.jbus_ratio = RATIO_W'($urandom_range(2, 31));
    bus.dram_ratio = RATIO_W'($urandom_range(2, 31));
    repeat (35) step("post_rst");

    // Minimum / illegal ratio on DRAM
    bus.sync_en    = 1'b0;
    bus.jbus_ratio = RATIO_W'(5);
    bus.dram_ratio = RATIO_W'(1);
    step("idle");
    bus.sync_en = 1'b1;
    repeat (8) step("min");
    bus.sync_en = 1'b0;
    repeat (2) step("min");
    bus.dram_ratio = RATIO_W'(7);
    bus.sync_en    = 1'b1;
    repeat (6) step("min");

    // Randomized run
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) bus.jbus_ratio = RATIO_W'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) bus.dram_ratio = RATIO_W'($urandom_range(0, 31));
      bus.sync_en = ($urandom_range(0, 24) != 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctu_sync_pulse_gen.md
# ctu_sync_pulse_gen

Generates the four global sync pulses (`jbus_rx_sync_global`, `jbus_tx_sync_global`, `dram_rx_sync_global`, `dram_tx_sync_global`) in the CMP clock domain. It sits in the clock control unit, directly upstream of every cluster header's sync distribution stage. Two independent phase counters track the JBUS and DRAM clock periods as programmable CMP-cycle ratios. Each counter emits one-cycle rx (capture) and tx (launch) strobes at fixed phases of its slow-clock period.

## Interface
- `RATIO_W`, 5: width of ratio inputs and phase counters; legal ratios 2..2^RATIO_W-1.
- `RX_OFFSET`, 1: phase at which rx pulses fire; must be 0 or 1 (always < minimum ratio 2).
- `cmp_gclk` in 1: CMP clock; the only clock.
- `cmp_grst_l` in 1: reset; asynchronous, active-low.
- `sync_en` in 1: run enable; low holds both counters at phase 0 with pulses off.
- `jbus_ratio` in RATIO_W: CMP cycles per JBUS cycle.
- `dram_ratio` in RATIO_W: CMP cycles per DRAM cycle.
- `jbus_rx_sync_global` out 1: JBUS capture strobe.
- `jbus_tx_sync_global` out 1: JBUS launch strobe.
- `dram_rx_sync_global` out 1: DRAM capture strobe.
- `dram_tx_sync_global` out 1: DRAM launch strobe.
- `ratio_err` out 1: sticky illegal-ratio flag (see Configuration).

## Operation
- Each domain (JBUS, DRAM) has:
  - an active-ratio register R, loaded from the corresponding ratio input;
  - a phase counter P, counting 0..R-1.
- The two domains are identical and fully independent. They share only `sync_en`.
- Clamping: ratio input values 0 or 1 load as 2.
- States per domain:
  - IDLE: `sync_en`=0. P=0 and R reloads from its input every cycle. Outputs are 0.
  - RUN: `sync_en`=1. P increments each cycle and wraps from R-1 to 0.
- Transitions:
  - IDLE→RUN at the first edge that samples `sync_en`=1.
  - RUN→IDLE at the first edge that samples `sync_en`=0.
- Ratio update while in RUN:
  - R reloads only at the wrap edge, the one that ends the P=R-1 cycle.
  - Ratio changes mid-period have no effect until that boundary. No short or long period is ever produced.
- Pulses while in RUN:
  - rx is high during the cycle where P==RX_OFFSET.
  - tx is high during the cycle where P==R-1.
  - With R=2 and RX_OFFSET=1, rx and tx are high in the same cycle. This is legal.
- All outputs come straight from flops. There is no combinational path from any input to any output.

## Timing
- Reset (`cmp_grst_l` low, asynchronous): P=0, R=2, all four pulses 0, `ratio_err`=0. Reset asserted mid-period aborts immediately, with no partial pulse.
- Cycle numbering: the edge that samples `sync_en`=1 is E0. Cycle k is the cycle following edge Ek.
  - Phase in cycle k is k mod R (for constant R).
  - First tx occurs in cycle R-1.
  - First rx occurs in cycle RX_OFFSET.
- Pulse width is exactly 1 CMP cycle. Period is exactly R cycles.
- Disable: the edge sampling `sync_en`=0 forces all pulses to 0 and P to 0 in the following cycle, including a pulse due that cycle.
- Re-enable restarts from phase 0. JBUS and DRAM phase 0 therefore coincide at cycle 0 of each enable.

## Configuration
- Macro: `CTU_SYNC_RATIO_CHECK_EN`.
- Defined:
  - `ratio_err` sets on any ratio-register load where the input was 0 or 1.
  - It stays set until reset. `sync_en` does not clear it.
- Not defined:
  - Clamping still applies.
  - `ratio_err` is tied to 0 and no check logic is built.

## Test plan
- Basic periods: reset, then `jbus_ratio`=4, `dram_ratio`=6, RX_OFFSET=1, `sync_en`=1 at E0.
  - JBUS rx in cycles 1,5,9; JBUS tx in cycles 3,7,11.
  - DRAM rx in cycles 1,7,13; DRAM tx in cycles 5,11,17.
- Ratio change mid-period: JBUS running at 4; change `jbus_ratio` to 3 during cycle 5.
  - tx still fires in cycle 7.
  - After that: rx in cycles 9,12; tx in cycles 10,13.
- Disable and re-enable:
  - Drop `sync_en` at the edge ending cycle 6 (JBUS ratio 4): no tx in cycle 7, all outputs 0.
  - Re-enable: pulses restart at relative cycles 1 (rx) and 3 (tx).
- Reset mid-operation: assert `cmp_grst_l`=0 asynchronously during a tx cycle.
  - Outputs drop immediately.
  - After release and enable, the first tx arrives at cycle R-1.
- Minimum and illegal ratio: `dram_ratio`=1.
  - DRAM rx and tx are both high every other cycle (cycles 1,3,5).
  - `ratio_err`=1 with the macro defined, 0 without it. It stays 1 after `sync_en` toggles.
